// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory image loader.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int DEFAULT_DATA_LENGTH = 32;
  localparam int DEFAULT_MEM_LENGTH  = 32;

endpackage

// File: rtl/byte_packer.sv
// Packs an incoming byte stream little-endian into one memory word.
// word_full and word_nxt are combinational so the loader can capture the
// completed word on the same edge that accepts its last byte.
module byte_packer #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic [7:0]             in_data,
  output logic                   word_full,
  output logic [DATA_LENGTH-1:0] word_nxt
);

  localparam int NB = DATA_LENGTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  logic [BW-1:0]          byte_cnt;
  logic [DATA_LENGTH-1:0] word_q;

  // Insert the incoming byte at the current byte lane.
  always_comb begin
    word_nxt  = word_q;
    word_full = load && (byte_cnt == LAST_BYTE);
    if (load) begin
      word_nxt[{byte_cnt, 3'b000} +: 8] = in_data;
    end
  end

  // Byte counter and partial word; both hold while no byte is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (load) begin
      word_q   <= word_nxt;
      byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Loads MEM_LENGTH words into a memory from a byte stream.
//
// state | meaning
// IDLE  | waiting for start, no session
// RECV  | accepting bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | all words written, done held until next start
module mem_loader
  import mem_pkg::*;
#(
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter int MEM_LENGTH  = DEFAULT_MEM_LENGTH,
  localparam int AW = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [DATA_LENGTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_LENGTH - 1);

  loader_state_t          state;
  logic [AW-1:0]          word_addr;
  logic                   pk_clear;
  logic                   pk_load;
  logic                   pk_full;
  logic [DATA_LENGTH-1:0] pk_word;

  // A fresh session or an abort discards any partial word.
  always_comb begin
    pk_clear = abort || (start && ((state == IDLE) || (state == DONE)));
    pk_load  = (state == RECV) && in_ready && in_valid && !abort;
  end

  byte_packer #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .load     (pk_load),
    .in_data  (in_data),
    .word_full(pk_full),
    .word_nxt (pk_word)
  );

  // Session FSM with registered outputs; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_addr <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        in_ready <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= RECV;
              word_addr <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          RECV: begin
            if (pk_full) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              wr_en    <= 1'b1;
              wr_addr  <= word_addr;
              wr_data  <= pk_word;
            end
          end
          WRITE: begin
            if (word_addr == LAST_ADDR) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RECV;
              word_addr <= word_addr + 1'b1;
              in_ready  <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued as words are
// driven and checked when wr_en appears.
module tb_mem_loader;

  localparam int DL = 32;
  localparam int ML = 32;
  localparam int AW = 5;
  localparam int NB = DL / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DL-1:0] wr_data;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DL-1:0] sb[$];

  mem_loader #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DL-1:0] word_val(input int k, input int off);
    logic [DL-1:0] w;
    w = '0;
    for (int j = 0; j < NB; j++) w[j*8 +: 8] = 8'((k*NB + j + off) & 255);
    return w;
  endfunction

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h required no write", wr_addr, wr_data);
      end else begin
        logic [AW+DL-1:0] exp;
        exp = sb.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          n_fail++;
          $display("FAIL write_content: addr=%0d data=%h required addr=%0d data=%h",
                   wr_addr, wr_data, exp[AW+DL-1:DL], exp[DL-1:0]);
        end
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL in_ready_in_write: in_ready=%b required 0", in_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input int k, input int off, input bit gaps);
    sb.push_back({AW'(k), word_val(k, off)});
    for (int j = 0; j < NB; j++) send_byte(8'((k*NB + j + off) & 255), gaps);
    n_checks++;
    if (wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency: word=%0d wr_en=%b required 1", k, wr_en);
    end
  endtask

  task automatic check_empty(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d writes missing required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic load_image(input int off, input bit gaps);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL session_start: done/busy/in_ready=%b required 011", {done, busy, in_ready});
    end
    for (int k = 0; k < ML; k++) send_word(k, off, gaps);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, busy, in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL session_done: done/busy/in_ready=%b required 100", {done, busy, in_ready});
    end
    check_empty("image_writes");
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b required all 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, in_ready, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy/in_ready/done=%b required 000", {busy, in_ready, done});
    end
  endtask

  task automatic test_stream;
    load_image(0, 1'b0);
  endtask

  task automatic test_gaps;
    load_image(0, 1'b1);
  endtask

  task automatic test_abort;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_done: done=%b required 0", done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) send_word(k, 0, 1'b0);
    send_byte(8'h14, 1'b0);
    send_byte(8'h15, 1'b0);
    in_data = 8'h16;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({busy, in_ready, done, wr_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: busy/in_ready/done/wr_en=%b required 0000", {busy, in_ready, done, wr_en});
    end
    repeat (10) @(negedge clk);
    check_empty("abort_writes");
    load_image(0, 1'b0);
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(0, 0, 1'b0);
    send_word(1, 0, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h09, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b wr_en=%b addr=%0d data=%h busy=%b done=%b required all 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({busy, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_autostart: busy/in_ready=%b required 00", {busy, in_ready});
    end
    check_empty("reset_writes");
  endtask

  task automatic test_start_ignored;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(0, 0, 1'b0);
    sb.push_back({AW'(1), word_val(1, 0)});
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_while_busy: busy/in_ready=%b required 11", {busy, in_ready});
    end
    send_byte(8'h06, 1'b0);
    send_byte(8'h07, 1'b0);
    n_checks++;
    if (wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_write: wr_en=%b required 1", wr_en);
    end
    send_byte(8'h08, 1'b0);
    in_valid = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({busy, in_ready, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_wins: busy/in_ready/done=%b required 000", {busy, in_ready, done});
    end
    repeat (10) @(negedge clk);
    check_empty("start_abort_writes");
  endtask

  task automatic test_restart;
    load_image(0, 1'b0);
    load_image(8'h80, 1'b1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
